// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the register file write port, one buffered write per cycle.
// Define ARB_ROUND_ROBIN_EN for round-robin on contended different-address grants (default: req0 priority).
module regfile_wb_arbiter #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0Valid,
    input  logic [ADDR_W-1:0]      req0Addr,
    input  logic [WIDTH-1:0]       req0Data,
    output logic                   req0Ready,
    input  logic                   req1Valid,
    input  logic [ADDR_W-1:0]      req1Addr,
    input  logic [WIDTH-1:0]       req1Data,
    output logic                   req1Ready,
    output logic                   writeEnable,
    output logic [ADDR_W-1:0]      writeAddr,
    output logic [WIDTH-1:0]       d,
    output logic [2**ADDR_W-1:0]   pendingMask
);

    localparam int NREG = 2**ADDR_W;

    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] req_addr [2];
    logic [WIDTH-1:0]  req_data [2];

    logic [1:0]        full_reg;
    logic [1:0]        full_next;
    logic [ADDR_W-1:0] addr_reg [2];
    logic [WIDTH-1:0]  data_reg [2];
    // age_reg = 1 means buffer 1 holds the older write
    logic              age_reg;
    logic              age_next;
`ifdef ARB_ROUND_ROBIN_EN
    logic              rr_last_reg;
`endif

    logic              grant_idx;
    logic              contended;
    logic              any_full;
    logic [1:0]        granted;
    logic [1:0]        ready;
    logic [1:0]        load;

    assign req_valid   = {req1Valid, req0Valid};
    assign req_addr[0] = req0Addr;
    assign req_addr[1] = req1Addr;
    assign req_data[0] = req0Data;
    assign req_data[1] = req1Data;

    assign contended = full_reg[0] & full_reg[1];
    assign any_full  = full_reg[0] | full_reg[1];

    always_comb begin
        grant_idx = 1'b0;
        if (full_reg[1] && !full_reg[0]) begin
            grant_idx = 1'b1;
        end else if (contended) begin
            if (addr_reg[0] == addr_reg[1]) begin
                grant_idx = age_reg;
            end else begin
`ifdef ARB_ROUND_ROBIN_EN
                grant_idx = ~rr_last_reg;
`else
                grant_idx = 1'b0;
`endif
            end
        end
    end

    // A granted buffer can be refilled in the same cycle it drains
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            assign granted[gi]   = full_reg[gi] && (grant_idx == 1'(gi));
            assign ready[gi]     = reset && (!full_reg[gi] || granted[gi]);
            assign load[gi]      = req_valid[gi] && ready[gi];
            assign full_next[gi] = load[gi] || (full_reg[gi] && !granted[gi]);
        end
    endgenerate

    always_comb begin
        age_next = age_reg;
        if (load[0] && load[1]) begin
            age_next = 1'b0;
        end else if (load[0]) begin
            age_next = 1'b1;
        end else if (load[1]) begin
            age_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            full_reg <= 2'b00;
            age_reg  <= 1'b0;
        end else begin
            full_reg <= full_next;
            age_reg  <= age_next;
        end
        for (int i = 0; i < 2; i++) begin
            if (load[i]) begin
                addr_reg[i] <= req_addr[i];
                data_reg[i] <= req_data[i];
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_last_reg <= 1'b1;
        end else if (contended) begin
            rr_last_reg <= grant_idx;
        end
    end
`endif

    assign req0Ready   = ready[0];
    assign req1Ready   = ready[1];
    assign writeEnable = reset && any_full;
    assign writeAddr   = any_full ? addr_reg[grant_idx] : '0;
    assign d           = any_full ? data_reg[grant_idx] : '0;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_mask
            assign pendingMask[gi] = (full_reg[0] && (addr_reg[0] == ADDR_W'(gi))) ||
                                     (full_reg[1] && (addr_reg[1] == ADDR_W'(gi)));
        end
    endgenerate

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: per-cycle model comparison plus hand-computed directed checks.
module tb_regfile_wb_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req0Valid, req1Valid;
    logic [2:0]  req0Addr, req1Addr;
    logic [15:0] req0Data, req1Data;
    logic        req0Ready, req1Ready;
    logic        writeEnable;
    logic [2:0]  writeAddr;
    logic [15:0] d;
    logic [7:0]  pendingMask;

    regfile_wb_arbiter #(.WIDTH(16), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .req0Valid(req0Valid), .req0Addr(req0Addr), .req0Data(req0Data), .req0Ready(req0Ready),
        .req1Valid(req1Valid), .req1Addr(req1Addr), .req1Data(req1Data), .req1Ready(req1Ready),
        .writeEnable(writeEnable), .writeAddr(writeAddr), .d(d), .pendingMask(pendingMask)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: buffers stamped with the cycle they were loaded; smaller stamp = older
    typedef struct packed {
        logic        full;
        logic [2:0]  addr;
        logic [15:0] data;
        int          stamp;
    } mbuf_t;

    mbuf_t       mb [2];
    logic [15:0] rf_model [8];
    logic [15:0] rf_dut [8];
    int          last_winner = 1;
    int          cyc_no = 0;

    initial begin
        for (int i = 0; i < 2; i++) mb[i] = '0;
        for (int r = 0; r < 8; r++) begin
            rf_model[r] = '0;
            rf_dut[r]   = '0;
        end
    end

    initial begin
        int g;
        bit both;
        logic e_rdy0, e_rdy1, e_we;
        logic [2:0] e_addr;
        logic [15:0] e_d;
        logic [7:0] e_mask;
        forever begin
            @(negedge clk);
            #2;
            both = mb[0].full && mb[1].full;
            g = -1;
            if (mb[0].full && !mb[1].full) g = 0;
            else if (!mb[0].full && mb[1].full) g = 1;
            else if (both) begin
                if (mb[0].addr == mb[1].addr) g = (mb[1].stamp < mb[0].stamp) ? 1 : 0;
                else if (RR) g = (last_winner == 0) ? 1 : 0;
                else g = 0;
            end
            e_rdy0 = reset && (!mb[0].full || g == 0);
            e_rdy1 = reset && (!mb[1].full || g == 1);
            e_we   = reset && (g >= 0);
            e_addr = (g >= 0) ? mb[g].addr : 3'd0;
            e_d    = (g >= 0) ? mb[g].data : 16'd0;
            e_mask = 8'd0;
            for (int i = 0; i < 2; i++)
                if (mb[i].full) e_mask[mb[i].addr] = 1'b1;
            check("cmp_ready0", 32'(req0Ready), 32'(e_rdy0));
            check("cmp_ready1", 32'(req1Ready), 32'(e_rdy1));
            check("cmp_we", 32'(writeEnable), 32'(e_we));
            check("cmp_waddr", 32'(writeAddr), 32'(e_addr));
            check("cmp_d", 32'(d), 32'(e_d));
            check("cmp_mask", 32'(pendingMask), 32'(e_mask));
            if (writeEnable === 1'b1) begin
                rf_dut[writeAddr] = d;
                $display("t=%0t write reg%0d <= %04h", $time, writeAddr, d);
            end
            @(posedge clk);
            if (!reset) begin
                mb[0].full  = 1'b0;
                mb[1].full  = 1'b0;
                last_winner = 1;
            end else begin
                if (g >= 0) begin
                    rf_model[mb[g].addr] = mb[g].data;
                    if (both) last_winner = g;
                    mb[g].full = 1'b0;
                end
                if (req0Valid && e_rdy0) begin
                    mb[0].full = 1'b1; mb[0].addr = req0Addr; mb[0].data = req0Data; mb[0].stamp = cyc_no;
                end
                if (req1Valid && e_rdy1) begin
                    mb[1].full = 1'b1; mb[1].addr = req1Addr; mb[1].data = req1Data; mb[1].stamp = cyc_no;
                end
            end
            cyc_no++;
        end
    end

    task automatic cyc(input logic r, input logic v0, input logic [2:0] a0, input logic [15:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [15:0] d1);
        @(negedge clk);
        reset = r;
        req0Valid = v0; req0Addr = a0; req0Data = d0;
        req1Valid = v1; req1Addr = a1; req1Data = d1;
        #3;
    endtask

    task automatic idle(input logic r);
        cyc(r, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    endtask

    initial begin
        reset = 1'b0;
        req0Valid = 1'b0; req0Addr = '0; req0Data = '0;
        req1Valid = 1'b0; req1Addr = '0; req1Data = '0;

        // Reset held with req0 offering
        repeat (2) begin
            cyc(1'b0, 1'b1, 3'd1, 16'h0005, 1'b0, 3'd0, 16'd0);
            check("rst_ready0", 32'(req0Ready), 32'd0);
            check("rst_ready1", 32'(req1Ready), 32'd0);
            check("rst_we", 32'(writeEnable), 32'd0);
            check("rst_mask", 32'(pendingMask), 32'd0);
        end
        cyc(1'b1, 1'b1, 3'd1, 16'h0005, 1'b0, 3'd0, 16'd0);
        check("t1_ready0", 32'(req0Ready), 32'd1);
        check("t1_mask_excl", 32'(pendingMask), 32'd0);
        idle(1'b1);
        check("t1_we", 32'(writeEnable), 32'd1);
        check("t1_waddr", 32'(writeAddr), 32'd1);
        check("t1_d", 32'(d), 32'h0005);
        check("t1_mask", 32'(pendingMask), 32'h02);
        idle(1'b1);
        check("t1_we_off", 32'(writeEnable), 32'd0);

        // Same-edge accept, distinct addresses
        cyc(1'b1, 1'b1, 3'd2, 16'h1111, 1'b1, 3'd3, 16'h2222);
        check("t2_ready0", 32'(req0Ready), 32'd1);
        check("t2_ready1", 32'(req1Ready), 32'd1);
        idle(1'b1);
        check("t2_first", 32'({writeAddr, d}), 32'({3'd2, 16'h1111}));
        idle(1'b1);
        check("t2_second", 32'({writeAddr, d}), 32'({3'd3, 16'h2222}));
        idle(1'b1);
        check("t2_we_off", 32'(writeEnable), 32'd0);

        // Sustained contention, distinct addresses (reset restarts arbitration at req0)
        idle(1'b0);
        for (int c = 0; c < 6; c++) begin
            cyc(1'b1, 1'b1, 3'd5, 16'h5000 + 16'(c), 1'b1, 3'd6, 16'h6000 + 16'(c));
            if (c >= 1) check("t3_grant_addr", 32'(writeAddr), (RR && (c % 2 == 0)) ? 32'd6 : 32'd5);
            if (!RR && c >= 1) check("t3_ready1_stall", 32'(req1Ready), 32'd0);
        end
        repeat (3) idle(1'b1);

        // Same address, req0 then req1 on consecutive edges
        cyc(1'b1, 1'b1, 3'd4, 16'hAAAA, 1'b0, 3'd0, 16'd0);
        cyc(1'b1, 1'b0, 3'd0, 16'd0, 1'b1, 3'd4, 16'hBBBB);
        check("t4_first", 32'(d), 32'hAAAA);
        check("t4_ready1", 32'(req1Ready), 32'd1);
        idle(1'b1);
        check("t4_second", 32'({writeAddr, d}), 32'({3'd4, 16'hBBBB}));
        idle(1'b1);
        check("t4_reg4", 32'(rf_dut[4]), 32'hBBBB);

        // Same address, loaded on the same edge: req0 counts older
        cyc(1'b1, 1'b1, 3'd4, 16'h00A0, 1'b1, 3'd4, 16'h00B1);
        idle(1'b1);
        check("t4s_first", 32'(d), 32'h00A0);
        idle(1'b1);
        check("t4s_second", 32'(d), 32'h00B1);
        idle(1'b1);

        // Same address with buffer 1 older: buffer 1 must win over req0 priority
        idle(1'b0);
        cyc(1'b1, 1'b1, 3'd1, 16'h0111, 1'b1, 3'd4, 16'h0444);
        cyc(1'b1, 1'b1, 3'd4, 16'h0555, 1'b0, 3'd0, 16'd0);
        check("age_first", 32'(writeAddr), 32'd1);
        check("age_refill", 32'(req0Ready), 32'd1);
        idle(1'b1);
        check("age_older", 32'(d), 32'h0444);
        idle(1'b1);
        check("age_younger", 32'(d), 32'h0555);
        idle(1'b1);

        // Reset with both buffers full discards them
        cyc(1'b1, 1'b1, 3'd2, 16'hDEAD, 1'b1, 3'd3, 16'hBEEF);
        idle(1'b0);
        check("t5_we_rst", 32'(writeEnable), 32'd0);
        idle(1'b1);
        check("t5_we_after", 32'(writeEnable), 32'd0);
        check("t5_mask_after", 32'(pendingMask), 32'd0);
        idle(1'b1);
        check("t5_reg2", 32'(rf_dut[2]), 32'h1111);
        check("t5_reg3", 32'(rf_dut[3]), 32'h2222);

        // req0 streaming alone
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 3'(i), 16'h0100 + 16'(i), 1'b0, 3'd0, 16'd0);
            check("t6_ready0", 32'(req0Ready), 32'd1);
            if (i >= 1) check("t6_we", 32'(writeEnable), 32'd1);
        end
        idle(1'b1);
        check("t6_we_last", 32'(writeEnable), 32'd1);
        idle(1'b1);
        check("t6_we_off", 32'(writeEnable), 32'd0);
        repeat (2) idle(1'b1);

        for (int r = 0; r < 8; r++) check("final_reg", 32'(rf_dut[r]), 32'(rf_model[r]));
        check("model_reg4", 32'(rf_model[4]), 32'h0555);
        check("model_reg3", 32'(rf_model[3]), 32'h0103);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
